// File: rtl/cook_timer_ctrl.sv
// Microwave cook timer sequencer: keypad entry, BCD mm:ss countdown, magnetron gating.
// Optional completion beeper is enabled by defining COOK_BEEP_EN.
module cook_timer_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        door_open,
  output logic [15:0] time_bcd,
  output logic        mag_on,
  output logic        done,
  output logic [2:0]  state
`ifdef COOK_BEEP_EN
  ,
  output logic        beep
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COOK   = 3'd1,
    PAUSED = 3'd2,
    DONE   = 3'd3
  } state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("cook_timer_ctrl: TICK_DIV must be at least 2");
  end
  if (BEEP_TICKS < 1) begin : g_bad_beep_ticks
    $error("cook_timer_ctrl: BEEP_TICKS must be at least 1");
  end

  state_t          cur;
  logic [PW-1:0]   prescale;
  logic            tick;
  logic [15:0]     dec_time;

`ifdef COOK_BEEP_EN
  localparam int BW = $clog2(BEEP_TICKS + 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);
  logic [BW-1:0]   beep_cnt;
`endif

  // One-second borrow chain across the four BCD digits; the 0001 case is handled by the FSM.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick     = (prescale == PRE_LAST);
  assign dec_time = bcd_dec(time_bcd);
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (clr) begin
      cur      <= IDLE;
      time_bcd <= 16'h0000;
      mag_on   <= 1'b0;
      done     <= 1'b0;
      prescale <= '0;
`ifdef COOK_BEEP_EN
      beep     <= 1'b0;
      beep_cnt <= '0;
`endif
    end else begin
      case (cur)
        IDLE: begin
          if (stop) begin
            time_bcd <= 16'h0000;
          end else if (start) begin
            if (time_bcd != 16'h0000 && !door_open) begin
              cur      <= COOK;
              prescale <= '0;
              mag_on   <= 1'b1;
            end
          end else if (key_valid && key_digit <= 4'd9 && time_bcd[3:0] <= 4'd5) begin
            // Rejecting keys while sec_ones>5 keeps sec_tens a legal 0-5 after the shift.
            time_bcd <= {time_bcd[11:0], key_digit};
          end
        end

        COOK: begin
          if (door_open || stop) begin
            cur    <= PAUSED;
            mag_on <= 1'b0;
          end else if (tick) begin
            prescale <= '0;
            if (time_bcd == 16'h0001) begin
              cur      <= DONE;
              time_bcd <= 16'h0000;
              mag_on   <= 1'b0;
              done     <= 1'b1;
`ifdef COOK_BEEP_EN
              beep     <= 1'b1;
              beep_cnt <= '0;
`endif
            end else begin
              time_bcd <= dec_time;
            end
          end else begin
            prescale <= prescale + PW'(1);
          end
        end

        PAUSED: begin
          if (stop) begin
            cur      <= IDLE;
            time_bcd <= 16'h0000;
            prescale <= '0;
          end else if (start && !door_open) begin
            cur    <= COOK;
            mag_on <= 1'b1;
          end
        end

        DONE: begin
          if (stop || start || door_open) begin
            cur  <= IDLE;
            done <= 1'b0;
`ifdef COOK_BEEP_EN
            beep <= 1'b0;
`endif
          end
`ifdef COOK_BEEP_EN
          // Beep phase reuses the prescaler, so it lasts BEEP_TICKS whole ticks.
          else if (tick) begin
            prescale <= '0;
            if (beep_cnt == BEEP_LAST) begin
              cur  <= IDLE;
              done <= 1'b0;
              beep <= 1'b0;
            end else begin
              beep_cnt <= beep_cnt + BW'(1);
            end
          end else begin
            prescale <= prescale + PW'(1);
          end
`endif
        end

        default: begin
          cur    <= IDLE;
          mag_on <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cook_timer_ctrl.md
Name: cook_timer_ctrl

Overview:
Sequencing controller for the microwave's BCD countdown timer (mm:ss). It accepts keypad digits, runs and pauses cooking on start, stop and door events, and decrements the time once per prescaled tick. It gates the magnetron enable and raises a completion flag. It sits between the keypad/door inputs and the display and counter datapath.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s timer tick (minimum 2)
BEEP_TICKS, 3, number of ticks beep stays high in DONE (used only with COOK_BEEP_EN)

Ports:
clk  in  1  system clock, all logic on the rising edge
clr  in  1  synchronous reset, active-high
key_valid  in  1  one-cycle strobe, key_digit is valid
key_digit  in  4  keypad digit value
start  in  1  start/resume strobe
stop  in  1  stop/clear strobe
door_open  in  1  level signal, 1 = door open
time_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, registered
mag_on  out  1  magnetron enable, registered
done  out  1  cooking finished, registered
state  out  3  IDLE=0, COOK=1, PAUSED=2, DONE=3
beep  out  1  present only with COOK_BEEP_EN

Behaviour:
- Reset (clr=1 at clk edge): state=IDLE, time_bcd=0, mag_on=0, done=0, beep=0, prescaler=0. clr has priority over every other input.
- Input priority within one cycle: door_open > stop > start > key_valid.
- IDLE:
  - key_valid with key_digit<=9 and current sec_ones<=5: time_bcd <= {time_bcd[11:0], key_digit}. The old min_tens is discarded.
  - key_digit>9, or sec_ones>5: the key is ignored. This keeps sec_tens within 0-5.
  - stop: time_bcd <= 0.
  - start with time_bcd!=0 and door closed: go to COOK, prescaler <= 0.
  - start with time_bcd==0 or door open: ignored.
- COOK:
  - mag_on=1, registered, so it is high from the first cycle in COOK.
  - Prescaler counts 0..TICK_DIV-1. The cycle where it equals TICK_DIV-1 is a tick; prescaler wraps to 0.
  - On a tick, BCD decrement:
    - sec_ones 0->9 with borrow, otherwise -1.
    - On borrow: sec_tens 0->5 with borrow, otherwise -1.
    - On borrow: min_ones 0->9 with borrow, otherwise -1.
    - On borrow: min_tens -1.
  - Tick when time_bcd==0001: time_bcd <= 0, go to DONE the same edge, mag_on <= 0.
  - door_open or stop: go to PAUSED, mag_on <= 0 next edge. Prescaler holds its value; a tick coinciding with door_open or stop is not applied.
  - key_valid and start are ignored.
- PAUSED:
  - mag_on=0, prescaler and time are held.
  - start with door closed: go to COOK, prescaler continues from its held value.
  - stop (door open or closed): go to IDLE, time_bcd <= 0, prescaler <= 0.
  - Keys are ignored.
- DONE:
  - done=1, mag_on=0, time_bcd=0.
  - stop, start or door_open: go to IDLE, done <= 0.
- min_tens at 0 with a pending borrow cannot occur, because time==0001 terminates first.

Optional Feature:
COOK_BEEP_EN.
- Defined: beep port exists. beep=1 from entry into DONE for BEEP_TICKS ticks. The prescaler restarts at 0 on DONE entry. After the final beep tick, state goes to IDLE automatically and done <= 0. stop, start or door_open during the beep ends it immediately and goes to IDLE.
- Undefined: no beep port and no beep counter. DONE holds until stop, start or door_open.

Test Plan:
- Reset then keys 1,2,3,0: time_bcd=16'h1230, state=IDLE, mag_on=0.
- Keys 0,0,0,7 then key 4: the 4 is rejected because sec_ones=7>5, time_bcd stays 16'h0007. Key 10 is also ignored.
- TICK_DIV=4, time 16'h0100, start: mag_on=1 next cycle; after 4 cycles time=16'h0059; after 60 ticks DONE, done=1, mag_on=0.
- COOK with time 16'h0005, door_open for 10 cycles: PAUSED, time frozen, mag_on=0. Door closed then start: resumes, remaining ticks counted from the held prescaler value.
- start with time 0 is ignored. In COOK, stop gives PAUSED; a second stop gives IDLE with time 0. clr asserted mid-COOK: all outputs 0 after the next edge.
- With COOK_BEEP_EN, BEEP_TICKS=3, TICK_DIV=4: beep high for 12 cycles after DONE entry, then state=IDLE and done=0.
